// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init monitor slice.
// Contents:
//   - command encodings as {cs_n,ras_n,cas_n,we_n}
//   - error-code and FSM state enums
//   - mode-register field bit positions
//   - default init timing (the sdram_init constants live here)
//   - helpers: idle-cycle decode and mode-register legality
package sdram_pkg;

  localparam logic [3:0] CMD_DESELECT              = 4'b1111;
  localparam logic [3:0] CMD_NOP                   = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE             = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH          = 4'b0001;
  localparam logic [3:0] CMD_PROGRAM_MODE_REGISTER = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE                = 4'b0011;
  localparam logic [3:0] CMD_READ                  = 4'b0101;
  localparam logic [3:0] CMD_WRITE                 = 4'b0100;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_EARLY    = 3'd1,
    ERR_SEQ      = 3'd2,
    ERR_TIMING   = 3'd3,
    ERR_AR_COUNT = 3'd4,
    ERR_MODE     = 3'd5
  } err_code_t;

  typedef enum logic [1:0] {
    PAUSE_S   = 2'd0,
    REFRESH_S = 2'd1,
    READY_S   = 2'd2,
    ERR_S     = 2'd3
  } init_state_t;

  // Mode-register field positions on the address bus
  localparam int MODE_BL_LSB   = 0;
  localparam int MODE_AM_BIT   = 3;
  localparam int MODE_CAS_LSB  = 4;
  localparam int MODE_RSVD_LSB = 7;
  localparam int MODE_WM_BIT   = 9;
  // a[10] on PRECHARGE selects all banks
  localparam int PRE_ALL_BIT   = 10;

  // Power-up init timing for the W9864G6JT
  localparam int INIT_PAUSE_CYC   = 65536;
  localparam int INIT_TRP_CYC     = 3;
  localparam int INIT_TRC_CYC     = 7;
  localparam int INIT_TMRD_CYC    = 2;
  localparam int INIT_AR_REQUIRED = 8;

  // DESELECT ignores the other three lines; NOP is the only other idle code
  function automatic logic is_idle(input logic [3:0] cmd);
    return cmd[3] || (cmd == CMD_NOP);
  endfunction

  // Reserved bits must be zero, CAS latency 2 or 3, and bank select zero
  function automatic logic mode_ok(input logic [11:0] a, input logic [1:0] bs);
    logic [2:0] cas;
    cas = a[MODE_CAS_LSB +: 3];
    return (a[MODE_RSVD_LSB +: 2] == 2'b00) &&
           ((cas == 3'd2) || (cas == 3'd3)) &&
           (bs == 2'b00);
  endfunction

endpackage

// File: rtl/sdram_cmd_timing_check.sv
// Command spacing checker.
// Tracks the previous command and the number of cycles since it, and flags
// the current command when it arrives sooner than the previous command allows.
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   cmd_vld             cmd carries a sampled bus cycle
//   cmd                 sampled {cs_n,ras_n,cas_n,we_n}
//   timing_violation    current command is too close to the previous one
module sdram_cmd_timing_check
  import sdram_pkg::*;
#(
  parameter int TRP_CYC  = INIT_TRP_CYC,
  parameter int TRC_CYC  = INIT_TRC_CYC,
  parameter int TMRD_CYC = INIT_TMRD_CYC
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cmd_vld,
  input  logic [3:0] cmd,
  output logic       timing_violation
);

  logic       is_cmd_s;
  logic [3:0] required_s;
  logic       last_vld_r;
  logic [3:0] last_cmd_r;
  logic [3:0] gap_r;

  assign is_cmd_s = cmd_vld && !is_idle(cmd);

  // Minimum spacing owed to the previous command
  always_comb begin
    required_s = 4'd0;
    case (last_cmd_r)
      CMD_PRECHARGE:             required_s = 4'(TRP_CYC);
      CMD_AUTO_REFRESH:          required_s = 4'(TRC_CYC);
      CMD_PROGRAM_MODE_REGISTER: required_s = 4'(TMRD_CYC);
      default:                   required_s = 4'd0;
    endcase
  end

  assign timing_violation = is_cmd_s && last_vld_r && (gap_r < required_s);

  // Previous command and saturating gap; gap reads 1 on the cycle after a command
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_vld_r <= 1'b0;
      last_cmd_r <= CMD_NOP;
      gap_r      <= 4'd0;
    end else if (is_cmd_s) begin
      last_vld_r <= 1'b1;
      last_cmd_r <= cmd;
      gap_r      <= 4'd1;
    end else if (gap_r != 4'd15) begin
      gap_r <= gap_r + 4'd1;
    end else begin
      gap_r <= gap_r;
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// SDRAM power-up init monitor.
// Snoops the command bus and checks: pause, precharge-all, N auto-refreshes,
// mode-register program. Latches the first violation, captures mode fields.
// Bus inputs are registered first, so a command sampled on edge N shows up
// on the outputs after edge N+1.
// Ports:
//   clk_i, rst_n_i   memory clock, asynchronous active-low reset
//   cmd_i, a_i, bs_i command/address/bank as driven to the device
//   init_ok_o        legal init complete, no error
//   err_o            sticky error, err_code_o holds the first cause
//   burst_length_o, addr_mode_o, cas_latency_o, write_mode_o  captured mode fields
//   ar_count_o       auto-refreshes since reset, saturating at 15
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int PAUSE_CYC   = INIT_PAUSE_CYC,
  parameter int TRP_CYC     = INIT_TRP_CYC,
  parameter int TRC_CYC     = INIT_TRC_CYC,
  parameter int TMRD_CYC    = INIT_TMRD_CYC,
  parameter int AR_REQUIRED = INIT_AR_REQUIRED
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  cmd_i,
  input  logic [11:0] a_i,
  input  logic [1:0]  bs_i,
  output logic        init_ok_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic [2:0]  burst_length_o,
  output logic        addr_mode_o,
  output logic [2:0]  cas_latency_o,
  output logic        write_mode_o,
  output logic [3:0]  ar_count_o
);

  localparam logic [16:0] PAUSE_MAX = 17'(PAUSE_CYC);
  localparam logic [3:0]  AR_REQ    = 4'(AR_REQUIRED);

  logic        in_vld_r;
  logic [3:0]  cmd_q_r;
  logic [11:0] a_q_r;
  logic [1:0]  bs_q_r;

  init_state_t state_r, state_n;
  logic [16:0] pause_cnt_r, pause_cnt_n;
  err_code_t   err_sel_s, err_code_r;
  logic        is_cmd_s, timing_violation_s, ar_inc_s, capture_s;
  logic        init_ok_r, err_r, addr_mode_r, write_mode_r;
  logic [2:0]  burst_length_r, cas_latency_r;
  logic [3:0]  ar_count_r;
  logic        unused_a11_s;

  // a[11] plays no part in init checking
  assign unused_a11_s = a_q_r[11];

  // Sample the bus; in_vld_r keeps the reset value of the sample from counting as idle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_vld_r <= 1'b0;
      cmd_q_r  <= CMD_DESELECT;
      a_q_r    <= 12'd0;
      bs_q_r   <= 2'd0;
    end else begin
      in_vld_r <= 1'b1;
      cmd_q_r  <= cmd_i;
      a_q_r    <= a_i;
      bs_q_r   <= bs_i;
    end
  end

  assign is_cmd_s = in_vld_r && !is_idle(cmd_q_r);

  sdram_cmd_timing_check #(
    .TRP_CYC  (TRP_CYC),
    .TRC_CYC  (TRC_CYC),
    .TMRD_CYC (TMRD_CYC)
  ) u_timing (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .cmd_vld          (in_vld_r),
    .cmd              (cmd_q_r),
    .timing_violation (timing_violation_s)
  );

  // Init FSM next state; error checks are ordered so the lowest code wins
  always_comb begin
    state_n     = state_r;
    pause_cnt_n = pause_cnt_r;
    err_sel_s   = ERR_NONE;
    ar_inc_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      PAUSE_S: begin
        if (is_cmd_s) begin
          if (pause_cnt_r < PAUSE_MAX) begin
            err_sel_s = ERR_EARLY;
          end else if (!((cmd_q_r == CMD_PRECHARGE) && a_q_r[PRE_ALL_BIT])) begin
            err_sel_s = ERR_SEQ;
          end else if (timing_violation_s) begin
            err_sel_s = ERR_TIMING;
          end else begin
            state_n = REFRESH_S;
          end
        end else if (in_vld_r && (pause_cnt_r != PAUSE_MAX)) begin
          pause_cnt_n = pause_cnt_r + 17'd1;
        end else begin
          pause_cnt_n = pause_cnt_r;
        end
      end
      REFRESH_S: begin
        if (!is_cmd_s) begin
          state_n = REFRESH_S;
        end else if (cmd_q_r == CMD_AUTO_REFRESH) begin
          if (timing_violation_s) begin
            err_sel_s = ERR_TIMING;
          end else begin
            ar_inc_s = 1'b1;
          end
        end else if (cmd_q_r == CMD_PROGRAM_MODE_REGISTER) begin
          if (timing_violation_s) begin
            err_sel_s = ERR_TIMING;
          end else if (ar_count_r < AR_REQ) begin
            err_sel_s = ERR_AR_COUNT;
          end else if (!mode_ok(a_q_r, bs_q_r)) begin
            err_sel_s = ERR_MODE;
          end else begin
            capture_s = 1'b1;
            state_n   = READY_S;
          end
        end else begin
          err_sel_s = ERR_SEQ;
        end
      end
      READY_S: begin
        if (!is_cmd_s) begin
          state_n = READY_S;
        end else if (timing_violation_s) begin
          err_sel_s = ERR_TIMING;
        end else if (cmd_q_r == CMD_AUTO_REFRESH) begin
          ar_inc_s = 1'b1;
        end else if (cmd_q_r == CMD_PROGRAM_MODE_REGISTER) begin
          if (mode_ok(a_q_r, bs_q_r)) begin
            capture_s = 1'b1;
          end else begin
            err_sel_s = ERR_MODE;
          end
        end else begin
          state_n = READY_S;
        end
      end
      ERR_S:   state_n = ERR_S;
      default: state_n = PAUSE_S;
    endcase
  end

  // State, counters, captured fields and the sticky error latch
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r        <= PAUSE_S;
      pause_cnt_r    <= 17'd0;
      err_code_r     <= ERR_NONE;
      err_r          <= 1'b0;
      init_ok_r      <= 1'b0;
      ar_count_r     <= 4'd0;
      burst_length_r <= 3'd0;
      addr_mode_r    <= 1'b0;
      cas_latency_r  <= 3'd0;
      write_mode_r   <= 1'b0;
    end else if (err_sel_s != ERR_NONE) begin
      state_r    <= ERR_S;
      err_code_r <= err_sel_s;
      err_r      <= 1'b1;
      init_ok_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      pause_cnt_r <= pause_cnt_n;
      init_ok_r   <= (state_n == READY_S);
      if (ar_inc_s && (ar_count_r != 4'd15)) begin
        ar_count_r <= ar_count_r + 4'd1;
      end
      if (capture_s) begin
        burst_length_r <= a_q_r[MODE_BL_LSB +: 3];
        addr_mode_r    <= a_q_r[MODE_AM_BIT];
        cas_latency_r  <= a_q_r[MODE_CAS_LSB +: 3];
        write_mode_r   <= a_q_r[MODE_WM_BIT];
      end
    end
  end

  assign init_ok_o      = init_ok_r;
  assign err_o          = err_r;
  assign err_code_o     = err_code_r;
  assign burst_length_o = burst_length_r;
  assign addr_mode_o    = addr_mode_r;
  assign cas_latency_o  = cas_latency_r;
  assign write_mode_o   = write_mode_r;
  assign ar_count_o     = ar_count_r;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Scoreboard bench for sdram_init_monitor (PAUSE_CYC = 16).
// Stimulus tasks push the expected output snapshot with the cycle it is due;
// a negedge monitor pops and compares whatever is due.
module tb_sdram_init_monitor;
  import sdram_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [3:0]  cmd_i = CMD_NOP;
  logic [11:0] a_i = 12'd0;
  logic [1:0]  bs_i = 2'd0;
  logic        init_ok_o, err_o, addr_mode_o, write_mode_o;
  logic [2:0]  err_code_o, burst_length_o, cas_latency_o;
  logic [3:0]  ar_count_o;

  sdram_init_monitor #(.PAUSE_CYC(16)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .cmd_i          (cmd_i),
    .a_i            (a_i),
    .bs_i           (bs_i),
    .init_ok_o      (init_ok_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .burst_length_o (burst_length_o),
    .addr_mode_o    (addr_mode_o),
    .cas_latency_o  (cas_latency_o),
    .write_mode_o   (write_mode_o),
    .ar_count_o     (ar_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  int now_cyc = 0;
  int checks  = 0;
  int errors  = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] vec;
  } exp_t;
  exp_t q[$];
  exp_t e;

  logic [16:0] dut_vec;
  assign dut_vec = {init_ok_o, err_o, err_code_o, burst_length_o, addr_mode_o,
                    cas_latency_o, write_mode_o, ar_count_o};

  // Expected snapshot: {ok, err, code, bl, am, cas, wm, ar_count}
  function automatic logic [16:0] ev(input logic ok, input logic er, input logic [2:0] code,
                                     input logic [2:0] bl, input logic am, input logic [2:0] cas,
                                     input logic wm, input logic [3:0] arc);
    return {ok, er, code, bl, am, cas, wm, arc};
  endfunction

  // Scoreboard monitor
  always @(negedge clk_i) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL %s: check due at cycle %0d reached at %0d", e.name, e.cyc, cyc_cnt);
      end else if (dut_vec !== e.vec) begin
        errors++;
        $display("FAIL %s: got ok/err/code/bl/am/cas/wm/ar=%b/%b/%0d/%0d/%b/%0d/%b/%0d expected %b/%b/%0d/%0d/%b/%0d/%b/%0d",
                 e.name, dut_vec[16], dut_vec[15], dut_vec[14:12], dut_vec[11:9], dut_vec[8],
                 dut_vec[7:5], dut_vec[4], dut_vec[3:0], e.vec[16], e.vec[15], e.vec[14:12],
                 e.vec[11:9], e.vec[8], e.vec[7:5], e.vec[4], e.vec[3:0]);
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [11:0] a, input logic [1:0] bs);
    @(negedge clk_i);
    cmd_i = c;
    a_i = a;
    bs_i = bs;
    now_cyc = cyc_cnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(CMD_NOP, 12'd0, 2'd0);
  endtask

  // Result of the last driven command is visible two cycles later
  task automatic expect_out(input string nm, input logic [16:0] v);
    q.push_back('{now_cyc + 2, nm, v});
  endtask

  // Pulse reset; outputs are checked before any clock edge arrives
  task automatic apply_reset(input string nm);
    idle(2);
    @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    q.push_back('{cyc_cnt, nm, ev(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0)});
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  // Pause, precharge-all and n auto-refreshes, each 7 cycles after the previous command
  task automatic run_refresh(input int n_ar);
    idle(16);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    expect_out("pre_all", ev(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));
    for (int i = 1; i <= n_ar; i++) begin
      idle(6);
      drive(CMD_AUTO_REFRESH, 12'd0, 2'd0);
      expect_out("ar_step", ev(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 4'(i)));
    end
  endtask

  task automatic run_init(input int n_ar, input logic [11:0] mrs_a);
    run_refresh(n_ar);
    idle(6);
    drive(CMD_PROGRAM_MODE_REGISTER, mrs_a, 2'd0);
  endtask

  initial begin
    // Test 1: legal init; 12'h023 -> bl=3, cas=2
    apply_reset("reset_state");
    run_init(8, 12'h023);
    expect_out("init_ok", ev(1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 3'd2, 1'b0, 4'd8));
    // Test 5: re-program 12'h232 (bl=2, cas=3, wm=1), then ACTIVE too soon after it
    idle(2);
    drive(CMD_PROGRAM_MODE_REGISTER, 12'h232, 2'd0);
    expect_out("mrs_reprogram", ev(1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 3'd3, 1'b1, 4'd8));
    drive(CMD_ACTIVE, 12'd0, 2'd0);
    expect_out("active_tmrd", ev(1'b0, 1'b1, 3'd3, 3'd2, 1'b0, 3'd3, 1'b1, 4'd8));
    idle(8);
    drive(CMD_AUTO_REFRESH, 12'd0, 2'd0);
    expect_out("err_frozen", ev(1'b0, 1'b1, 3'd3, 3'd2, 1'b0, 3'd3, 1'b1, 4'd8));

    // Test 2: precharge at idle cycle 10, then legal traffic
    apply_reset("reset_t2");
    idle(9);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    expect_out("early_pre", ev(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));
    idle(20);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    idle(6);
    drive(CMD_AUTO_REFRESH, 12'd0, 2'd0);
    expect_out("early_sticky", ev(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));

    // Pause one idle short of the limit
    apply_reset("reset_t2b");
    idle(15);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    expect_out("early_by_one", ev(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));

    // Test 3: precharge without a10
    apply_reset("reset_t3a");
    idle(16);
    drive(CMD_PRECHARGE, 12'h000, 2'd0);
    expect_out("pre_not_all", ev(1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));

    // AR 5 after PRE is fine, next AR 6 later breaks tRC
    apply_reset("reset_t3b");
    idle(16);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    idle(4);
    drive(CMD_AUTO_REFRESH, 12'd0, 2'd0);
    expect_out("ar_after_trp", ev(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd1));
    idle(5);
    drive(CMD_AUTO_REFRESH, 12'd0, 2'd0);
    expect_out("ar_trc_short", ev(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 4'd1));

    // ACTIVE during refresh, also too soon: sequence error outranks timing
    apply_reset("reset_t3c");
    idle(16);
    drive(CMD_PRECHARGE, 12'h400, 2'd0);
    drive(CMD_ACTIVE, 12'd0, 2'd0);
    expect_out("seq_over_timing", ev(1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0));

    // Test 4: mode write after only 7 refreshes
    apply_reset("reset_t4a");
    run_init(7, 12'h023);
    expect_out("ar_count_short", ev(1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 4'd7));

    // CAS latency 1 rejected, fields not captured
    apply_reset("reset_t4b");
    run_init(8, 12'h013);
    expect_out("mode_bad_cas", ev(1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 4'd8));

    // Reserved bit a7 set
    apply_reset("reset_t4c");
    run_init(8, 12'h0A3);
    expect_out("mode_rsvd_bit", ev(1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 4'd8));

    // Test 6: reset mid-refresh, then full sequence again
    apply_reset("reset_t6");
    run_refresh(4);
    apply_reset("reset_mid_refresh");
    run_init(8, 12'h023);
    expect_out("init_after_reset", ev(1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 3'd2, 1'b0, 4'd8));

    idle(4);
    if (q.size() != 0) begin
      errors += q.size();
      checks += q.size();
      $display("FAIL scoreboard_drain: %0d expectations never compared", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
